// File: rtl/cb_base_agd.sv
// Covariance-block base-address generator: advance/retreat/load/clear of the CB base by a group interval.
// Optional bound checking is enabled by defining CB_AGD_BOUND_CHK_EN; otherwise arithmetic wraps on CB_AW bits.
module cb_base_agd #(
    parameter int unsigned      CB_AW     = 19,
    parameter int unsigned      ROW_LEN   = 10,
    parameter int unsigned      GRP_SHIFT = 3,
    parameter int unsigned      BASE_INIT = 2,
    parameter longint unsigned  CB_LIMIT  = (64'd1 << CB_AW) - 64'd1
) (
    input  logic                clk,
    input  logic                sys_rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [1:0]          req_op,
    input  logic [ROW_LEN-1:0]  group_cnt,
    input  logic [CB_AW-1:0]    load_addr,
    output logic [CB_AW-1:0]    CB_base_addr,
    output logic [CB_AW-1:0]    interval,
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam int unsigned        AW1       = CB_AW + 1;
    localparam logic [CB_AW-1:0]   BASE_VAL  = CB_AW'(BASE_INIT);
    localparam logic [CB_AW:0]     LIMIT_EXT = AW1'(CB_LIMIT);

    localparam logic [1:0] OP_ADVANCE = 2'b00;
    localparam logic [1:0] OP_RETREAT = 2'b01;
    localparam logic [1:0] OP_LOAD    = 2'b10;
    localparam logic [1:0] OP_CLEAR   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_SUM  = 2'd2,
        ST_UPD  = 2'd3
    } state_t;

    state_t               state_r;
    state_t               state_next_s;
    logic                 accept_s;

    logic [1:0]           op_r;
    logic [ROW_LEN-1:0]   gc_r;
    logic [CB_AW-1:0]     load_r;
    logic [CB_AW-1:0]     shift_r;
    logic [CB_AW-1:0]     offset_r;
    logic [CB_AW-1:0]     interval_r;
    logic [CB_AW-1:0]     base_r;
    logic                 done_r;
    logic                 err_r;
    logic                 busy_r;
    logic                 ready_r;

    logic [CB_AW:0]       sum_s;
    logic [CB_AW:0]       diff_s;
    logic                 bound_viol_s;
    logic [CB_AW-1:0]     base_next_s;
    logic                 err_next_s;

    assign accept_s = req_valid & ready_r;

    // State register
    always_ff @(posedge clk) begin
        if (!sys_rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state sequencing: fixed four-cycle walk for every op
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_next_s = ST_CALC;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_CALC: state_next_s = ST_SUM;
            ST_SUM:  state_next_s = ST_UPD;
            ST_UPD:  state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Candidate base values and bound classification for the latched op
    always_comb begin
        sum_s        = {1'b0, base_r} + {1'b0, interval_r};
        diff_s       = {1'b0, base_r} - {1'b0, interval_r};
        bound_viol_s = 1'b0;
        case (op_r)
            OP_ADVANCE: bound_viol_s = (sum_s > LIMIT_EXT);
            OP_RETREAT: bound_viol_s = diff_s[CB_AW] | (diff_s[CB_AW-1:0] < BASE_VAL);
            OP_LOAD:    bound_viol_s = ({1'b0, load_r} > LIMIT_EXT);
            OP_CLEAR:   bound_viol_s = 1'b0;
            default:    bound_viol_s = 1'b0;
        endcase
    end

    // Result selection; a violating op leaves the base untouched when checking is on
    always_comb begin
        base_next_s = base_r;
        err_next_s  = 1'b0;
        case (op_r)
            OP_ADVANCE: base_next_s = sum_s[CB_AW-1:0];
            OP_RETREAT: base_next_s = diff_s[CB_AW-1:0];
            OP_LOAD:    base_next_s = load_r;
            OP_CLEAR:   base_next_s = BASE_VAL;
            default:    base_next_s = base_r;
        endcase
`ifdef CB_AGD_BOUND_CHK_EN
        if (bound_viol_s) begin
            base_next_s = base_r;
            err_next_s  = 1'b1;
        end else begin
            err_next_s  = 1'b0;
        end
`else
        err_next_s = 1'b0;
`endif
    end

`ifndef CB_AGD_BOUND_CHK_EN
    logic unused_bound_s;
    assign unused_bound_s = bound_viol_s;
`endif

    // Datapath registers: latch at accept, interval pipeline, base commit at UPD
    always_ff @(posedge clk) begin
        if (!sys_rst_n) begin
            op_r       <= OP_ADVANCE;
            gc_r       <= {ROW_LEN{1'b0}};
            load_r     <= {CB_AW{1'b0}};
            shift_r    <= {CB_AW{1'b0}};
            offset_r   <= {CB_AW{1'b0}};
            interval_r <= {CB_AW{1'b0}};
            base_r     <= BASE_VAL;
            err_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        op_r   <= req_op;
                        gc_r   <= group_cnt;
                        load_r <= load_addr;
                        err_r  <= 1'b0;
                    end
                end
                ST_CALC: begin
                    shift_r  <= CB_AW'(gc_r[ROW_LEN-1:1]) << GRP_SHIFT;
                    offset_r <= (CB_AW'(1'b1) << GRP_SHIFT) | CB_AW'(gc_r[0]);
                end
                ST_SUM: begin
                    interval_r <= shift_r + offset_r;
                end
                ST_UPD: begin
                    base_r <= base_next_s;
                    err_r  <= err_next_s;
                end
                default: begin
                    base_r <= base_r;
                end
            endcase
        end
    end

    // Handshake/status flags registered from the upcoming state
    always_ff @(posedge clk) begin
        if (!sys_rst_n) begin
            done_r  <= 1'b0;
            busy_r  <= 1'b0;
            ready_r <= 1'b1;
        end else begin
            done_r  <= (state_r == ST_UPD);
            busy_r  <= (state_next_s != ST_IDLE);
            ready_r <= (state_next_s == ST_IDLE);
        end
    end

    assign req_ready    = ready_r;
    assign CB_base_addr = base_r;
    assign interval     = interval_r;
    assign busy         = busy_r;
    assign done         = done_r;
    assign err          = err_r;

endmodule

// File: tb/tb_cb_base_agd.sv
// Self-checking bench for cb_base_agd: directed cases plus randomized ops against a behavioural model.
module tb_cb_base_agd;

    localparam int unsigned AW     = 19;
    localparam longint unsigned MODV  = 64'd1 << AW;
    localparam longint unsigned LIMIT = MODV - 64'd1;
    localparam int unsigned BASE0  = 2;

    logic              clk;
    logic              sys_rst_n;
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_op;
    logic [9:0]        group_cnt;
    logic [AW-1:0]     load_addr;
    logic [AW-1:0]     CB_base_addr;
    logic [AW-1:0]     interval;
    logic              busy;
    logic              done;
    logic              err;

    int tests = 0;
    int fails = 0;
    longint unsigned m_base = BASE0;
    longint unsigned m_iv   = 0;
    bit m_err = 1'b0;

    cb_base_agd dut (
        .clk          (clk),
        .sys_rst_n    (sys_rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .group_cnt    (group_cnt),
        .load_addr    (load_addr),
        .CB_base_addr (CB_base_addr),
        .interval     (interval),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint unsigned obs, input longint unsigned exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Behavioural model: interval = 8*(gc/2) + 8 + (gc odd)
    task automatic model(input logic [1:0] op, input int unsigned gc, input longint unsigned la);
        longint unsigned nb;
        bit viol;
        m_iv = 64'd8 * (gc / 2) + 64'd8 + (gc % 2);
        viol = 1'b0;
        case (op)
            2'b00: begin
                nb = m_base + m_iv;
                viol = (nb > LIMIT);
                nb = nb % MODV;
            end
            2'b01: begin
                viol = (m_iv > m_base) || (m_base - m_iv < BASE0);
                nb = (m_base + MODV - m_iv) % MODV;
            end
            2'b10: begin
                nb = la;
                viol = (la > LIMIT);
            end
            default: nb = BASE0;
        endcase
`ifdef CB_AGD_BOUND_CHK_EN
        if (viol) begin
            m_err = 1'b1;
        end else begin
            m_err = 1'b0;
            m_base = nb;
        end
`else
        m_err = 1'b0;
        m_base = nb;
`endif
    endtask

    // Called at a negedge with req_ready high; returns at the negedge where done is high
    task automatic run_op(input logic [1:0] op, input int unsigned gc, input longint unsigned la, input bit keep);
        int cyc;
        model(op, gc, la);
        req_op    = op;
        group_cnt = gc[9:0];
        load_addr = la[AW-1:0];
        req_valid = 1'b1;
        @(negedge clk);
        chk("busy_after_accept", busy, 1);
        chk("ready_after_accept", req_ready, 0);
        chk("done_low_while_busy", done, 0);
        if (!keep) req_valid = 1'b0;
        group_cnt = 10'($urandom);
        load_addr = AW'($urandom);
        cyc = 1;
        while (!done && cyc < 8) begin
            @(negedge clk);
            cyc++;
        end
        chk("latency", cyc, 4);
        chk("done_pulse", done, 1);
        chk("base", CB_base_addr, m_base);
        chk("interval", interval, m_iv);
        chk("err", err, m_err);
        chk("ready_after_done", req_ready, 1);
        chk("busy_after_done", busy, 0);
    endtask

    initial begin
        sys_rst_n = 1'b0;
        req_valid = 1'b0;
        req_op    = 2'b00;
        group_cnt = 10'd0;
        load_addr = '0;
        repeat (3) @(negedge clk);
        chk("rst_base", CB_base_addr, 2);
        chk("rst_ready", req_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_interval", interval, 0);
        sys_rst_n = 1'b1;
        @(negedge clk);

        run_op(2'b00, 5, 0, 1'b0);
        chk("adv5_base_27", CB_base_addr, 27);
        chk("adv5_iv_25", interval, 25);
        @(negedge clk);
        chk("done_one_cycle", done, 0);

        run_op(2'b11, 0, 0, 1'b0);
        run_op(2'b00, 4, 0, 1'b1);
        chk("adv4_base_26", CB_base_addr, 26);
        run_op(2'b01, 4, 0, 1'b0);
        chk("ret4_base_2", CB_base_addr, 2);
        @(negedge clk);
        chk("held_valid_no_extra", busy, 0);

        run_op(2'b10, 0, 1000, 1'b0);
        chk("load_1000", CB_base_addr, 1000);
        run_op(2'b11, 7, 0, 1'b0);
        chk("clear_2", CB_base_addr, 2);
        chk("clear_err0", err, 0);

        run_op(2'b10, 0, 524280, 1'b0);
        run_op(2'b00, 0, 0, 1'b0);
`ifdef CB_AGD_BOUND_CHK_EN
        chk("bound_base", CB_base_addr, 524280);
        chk("bound_err", err, 1);
`else
        chk("wrap_base", CB_base_addr, 0);
        chk("wrap_err", err, 0);
`endif

        // Reset during SUM discards the op
        run_op(2'b11, 0, 0, 1'b0);
        req_op = 2'b00; group_cnt = 10'd5; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        sys_rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_base", CB_base_addr, 2);
        chk("midrst_done", done, 0);
        chk("midrst_ready", req_ready, 1);
        sys_rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("midrst_no_done", done, 0);
        end

        // Reset beats a simultaneous accept
        req_valid = 1'b1; sys_rst_n = 1'b0;
        @(negedge clk);
        chk("rst_vs_accept", busy, 0);
        req_valid = 1'b0; sys_rst_n = 1'b1;
        @(negedge clk);
        m_base = BASE0;
        m_err = 1'b0;

        for (int i = 0; i < 60; i++) begin
            logic [1:0] op;
            int unsigned gc;
            longint unsigned la;
            op = 2'($urandom_range(0, 3));
            gc = $urandom_range(0, 1023);
            la = longint'($urandom) % MODV;
            if ($urandom_range(0, 3) == 0) la = LIMIT - longint'($urandom_range(0, 20));
            run_op(op, gc, la, (i != 59) && ($urandom_range(0, 1) == 1));
        end
        @(negedge clk);
        chk("final_done_low", done, 0);
        chk("final_base", CB_base_addr, m_base);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
